serial_subtractor8: RTL and testbench
=====================================

SERIAL_SUBTRACTOR8 -- requirements
Module: serial_subtractor8

Interface
REQ-001 The block SHALL have no parameters; the operand width SHALL be fixed at 8 bits.
REQ-002 The block SHALL use a single clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 X  input  8  minuend; captured when start is accepted.
REQ-007 Y  input  8  subtrahend; captured when start is accepted.
REQ-008 B0  input  1  borrow-in; captured when start is accepted.
REQ-009 busy  output  1  high while the bit-serial operation runs.
REQ-010 done  output  1  single-cycle pulse when the result is valid.
REQ-011 D  output  8  difference X - Y - B0 (mod 256).
REQ-012 B8  output  1  borrow-out; 1 iff X < Y + B0 (unsigned).
REQ-013 V  output  1  signed (two's-complement) overflow of X - Y - B0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE, a rising edge with start=1 SHALL capture X, Y and B0 into internal shift registers and borrow flop, clear the 3-bit bit counter, and enter RUN.
REQ-016 In RUN, each rising edge SHALL process one bit, LSB first: d = x^y^b; b_next = (~x & y) | (~(x^y) & b).
REQ-017 The difference bit SHALL shift into the result register from the MSB side, so that after 8 RUN edges bit i of the result equals bit i of the difference.
REQ-018 RUN SHALL last exactly 8 edges (counter 0..7); on the edge processing bit 7, the FSM SHALL enter DONE and load D, B8 (the final borrow) and V.
REQ-019 V SHALL be computed as (X[7] ^ Y[7]) & (X[7] ^ D[7]), using the captured operands.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-021 Latency: start accepted at edge k -> done=1 in the cycle after edge k+8, and D/B8/V are valid in that cycle.
REQ-022 busy SHALL equal 1 exactly while in RUN, and 0 in IDLE and DONE.
REQ-023 start SHALL be ignored in RUN and DONE; no operand is queued.
REQ-024 D, B8 and V SHALL hold their last completed values until the next completion; they SHALL NOT change during RUN.
REQ-025 A start asserted in the cycle when done=1 SHALL be ignored; a new operation is accepted from IDLE on the following edge.
REQ-026 Changes on X, Y or B0 after capture SHALL NOT affect the operation in progress.
REQ-027 All outputs SHALL be registered, with no combinational path from the inputs to the outputs.

Reset
REQ-028 While rst_n=0, the block SHALL immediately, without a clock, force state=IDLE, busy=0, done=0, D=0x00, B8=0, V=0, and clear the counter, shift registers and borrow flop.
REQ-029 Reset asserted mid-RUN SHALL abort the operation; after release no done pulse occurs and D/B8/V remain 0 until a new start completes.
REQ-030 The first accepted start SHALL be on the first rising edge after rst_n deasserts.

Verification
REQ-031 X=0x05, Y=0x03, B0=0, start at edge k -> busy high for 8 cycles, done at k+8 with D=0x02, B8=0, V=0.
REQ-032 X=0x00, Y=0x01, B0=0 -> D=0xFF, B8=1, V=0; X=0x80, Y=0x01, B0=0 -> D=0x7F, B8=0, V=1.
REQ-033 X=0x7F, Y=0xFF, B0=0 -> D=0x80, B8=1, V=1; X=0x10, Y=0x0F, B0=1 -> D=0x00, B8=0, V=0.
REQ-034 Start X=0x05, Y=0x03, then assert start with X=0xAA, Y=0x55 during RUN and in the done cycle -> only 0x02 is produced and no extra done pulse; X/Y toggled mid-RUN do not change the result.
REQ-035 Complete 0x05-0x03, then start 0xFF-0x01 and assert rst_n=0 at RUN bit 4 -> outputs are immediately 0x00/0/0 and busy=0; after release, no done pulse until a new start.
REQ-036 Back-to-back operations: assert start on the first edge after done -> accepted, with identical 8-cycle latency; exhaustive random X/Y/B0 compared against (X - Y - B0) mod 256 with borrow and V.

Source files
------------

// File: rtl/serial_subtractor8.sv
// Bit-serial 8-bit subtractor: D = X - Y - B0 (mod 256), with borrow-out B8
// and signed overflow V. One bit per clock, LSB first, using a three-state FSM.
module serial_subtractor8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] X,
    input  logic [7:0] Y,
    input  logic       B0,
    output logic       busy,
    output logic       done,
    output logic [7:0] D,
    output logic       B8,
    output logic       V
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [7:0] r_x;
    logic [7:0] r_y;
    logic [7:0] r_res;
    logic       r_b;
    logic [2:0] r_cnt;
    logic [7:0] r_d;
    logic       r_b8;
    logic       r_v;

    logic       w_xb;
    logic       w_yb;
    logic       w_dbit;
    logic       w_bnext;
    logic       w_last;
    logic [7:0] w_res_next;

    // Current operand bits sit at the LSB of the right-shifting operand registers.
    assign w_xb       = r_x[0];
    assign w_yb       = r_y[0];
    assign w_dbit     = w_xb ^ w_yb ^ r_b;
    assign w_bnext    = (~w_xb & w_yb) | (~(w_xb ^ w_yb) & r_b);
    assign w_last     = (r_cnt == 3'd7);
    assign w_res_next = {w_dbit, r_res[7:1]};

    // Status outputs are decoded from the state register only, so nothing
    // on the input side reaches them combinationally.
    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign D    = r_d;
    assign B8   = r_b8;
    assign V    = r_v;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: start only matters in IDLE; DONE always lasts one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, shift one bit per RUN cycle, and
    // publish the result only on the cycle that processes bit 7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= 8'h00;
            r_y   <= 8'h00;
            r_res <= 8'h00;
            r_b   <= 1'b0;
            r_cnt <= 3'd0;
            r_d   <= 8'h00;
            r_b8  <= 1'b0;
            r_v   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x   <= X;
                        r_y   <= Y;
                        r_b   <= B0;
                        r_cnt <= 3'd0;
                    end
                end
                RUN: begin
                    r_x   <= {1'b0, r_x[7:1]};
                    r_y   <= {1'b0, r_y[7:1]};
                    r_b   <= w_bnext;
                    r_cnt <= r_cnt + 3'd1;
                    r_res <= w_res_next;
                    if (w_last) begin
                        // On bit 7, w_xb/w_yb are the captured X[7]/Y[7]
                        // and w_dbit is D[7].
                        r_d  <= w_res_next;
                        r_b8 <= w_bnext;
                        r_v  <= (w_xb ^ w_yb) & (w_xb ^ w_dbit);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor8.sv
// Directed and random bench for serial_subtractor8.
module tb_serial_subtractor8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] X;
    logic [7:0] Y;
    logic       B0;
    logic       busy;
    logic       done;
    logic [7:0] D;
    logic       B8;
    logic       V;

    int checks = 0;
    int errors = 0;

    serial_subtractor8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .X     (X),
        .Y     (Y),
        .B0    (B0),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .B8    (B8),
        .V     (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands with start for exactly one rising edge; returns at the
    // falling edge right after the accepting edge.
    task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic b0);
        @(negedge clk);
        X = x; Y = y; B0 = b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; reports cycles waited and busy-high cycles seen.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && cycles < 20) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        int cyc, bc;
        rst_n = 1'b0; start = 1'b0; X = 8'h00; Y = 8'h00; B0 = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if ({D, B8, V} !== 10'h000) begin errors++; $display("FAIL reset_outs got %h/%b/%b exp 00/0/0", D, B8, V); end
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, D, B8, V} !== 12'h000) begin errors++; $display("FAIL reset_hold got %h exp 000", {busy, done, D, B8, V}); end
        // Release reset and present start together: first edge must accept it.
        X = 8'h05; Y = 8'h03; B0 = 1'b0; start = 1'b1; rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_start_busy got %b exp 1", busy); end
        wait_done(cyc, bc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL first_start_latency got %0d exp 8", cyc); end
        checks++; if (D !== 8'h02) begin errors++; $display("FAIL first_start_D got %h exp 02", D); end
    endtask

    task automatic test_basic();
        int cyc, bc;
        start_op(8'h05, 8'h03, 1'b0);
        wait_done(cyc, bc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL basic_latency got %0d exp 8", cyc); end
        checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 8", bc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done got %b exp 0", busy); end
        checks++; if ({D, B8, V} !== {8'h02, 1'b0, 1'b0}) begin errors++; $display("FAIL basic_result got %h/%b/%b exp 02/0/0", D, B8, V); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
        // Outputs must hold the old result while the next operation runs.
        start_op(8'h00, 8'h01, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++; if ({D, B8, V} !== {8'h02, 1'b0, 1'b0}) begin errors++; $display("FAIL hold_during_run cyc %0d got %h/%b/%b exp 02/0/0", i, D, B8, V); end
            if (i < 7) @(negedge clk);
        end
        wait_done(cyc, bc);
        checks++; if ({D, B8, V} !== {8'hFF, 1'b1, 1'b0}) begin errors++; $display("FAIL vec_00_01 got %h/%b/%b exp FF/1/0", D, B8, V); end
    endtask

    task automatic test_vectors();
        logic [7:0] vx [3];
        logic [7:0] vy [3];
        logic       vb [3];
        logic [9:0] vexp [3];
        int cyc, bc;
        vx[0] = 8'h80; vy[0] = 8'h01; vb[0] = 1'b0; vexp[0] = {8'h7F, 1'b0, 1'b1};
        vx[1] = 8'h7F; vy[1] = 8'hFF; vb[1] = 1'b0; vexp[1] = {8'h80, 1'b1, 1'b1};
        vx[2] = 8'h10; vy[2] = 8'h0F; vb[2] = 1'b1; vexp[2] = {8'h00, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            start_op(vx[i], vy[i], vb[i]);
            wait_done(cyc, bc);
            checks++; if ({D, B8, V} !== vexp[i]) begin errors++; $display("FAIL vector_%0d got %h/%b/%b exp %h/%b/%b", i, D, B8, V, vexp[i][9:2], vexp[i][1], vexp[i][0]); end
        end
    endtask

    task automatic test_ignore_start();
        int cyc, extra;
        start_op(8'h05, 8'h03, 1'b0);
        start = 1'b1; X = 8'hAA; Y = 8'h55; B0 = 1'b1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            X = ~X; Y = ~Y; B0 = ~B0;
            cyc++;
        end
        checks++; if (cyc !== 8) begin errors++; $display("FAIL ignore_latency got %0d exp 8", cyc); end
        checks++; if ({D, B8, V} !== {8'h02, 1'b0, 1'b0}) begin errors++; $display("FAIL ignore_result got %h/%b/%b exp 02/0/0", D, B8, V); end
        // start stays high across the done cycle's closing edge.
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_done_start busy got %b exp 0", busy); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_no_extra got %0d exp 0", extra); end
        checks++; if (D !== 8'h02) begin errors++; $display("FAIL ignore_D_hold got %h exp 02", D); end
    endtask

    task automatic test_reset_midrun();
        int cyc, bc, seen;
        start_op(8'h05, 8'h03, 1'b0);
        wait_done(cyc, bc);
        checks++; if (D !== 8'h02) begin errors++; $display("FAIL midrun_pre got %h exp 02", D); end
        start_op(8'hFF, 8'h01, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midrun_ctrl got %b exp 00", {busy, done}); end
        checks++; if ({D, B8, V} !== 10'h000) begin errors++; $display("FAIL midrun_outs got %h/%b/%b exp 00/0/0", D, B8, V); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1 || D !== 8'h00 || B8 !== 1'b0 || V !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrun_after_release got %0d exp 0", seen); end
        start_op(8'h10, 8'h20, 1'b0);
        wait_done(cyc, bc);
        checks++; if ({D, B8, V} !== {8'hF0, 1'b1, 1'b0}) begin errors++; $display("FAIL midrun_restart got %h/%b/%b exp F0/1/0", D, B8, V); end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        start_op(8'h33, 8'h11, 1'b0);
        wait_done(cyc, bc);
        checks++; if (D !== 8'h22) begin errors++; $display("FAIL b2b_first got %h exp 22", D); end
        // start_op begins at the next falling edge, which is in IDLE.
        start_op(8'h01, 8'h02, 1'b1);
        wait_done(cyc, bc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL b2b_latency got %0d exp 8", cyc); end
        checks++; if ({D, B8, V} !== {8'hFE, 1'b1, 1'b0}) begin errors++; $display("FAIL b2b_second got %h/%b/%b exp FE/1/0", D, B8, V); end
    endtask

    task automatic test_random();
        int cyc, bc, sd, ud;
        logic [7:0] x, y;
        logic       b;
        logic [7:0] ed;
        logic       eb, ev;
        for (int n = 0; n < 40; n++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            b = 1'($urandom_range(0, 1));
            ud = int'(x) - int'(y) - int'(b);
            sd = int'($signed(x)) - int'($signed(y)) - int'(b);
            ed = 8'(ud);
            eb = (ud < 0);
            ev = (sd < -128) || (sd > 127);
            start_op(x, y, b);
            wait_done(cyc, bc);
            checks++; if ({D, B8, V} !== {ed, eb, ev} || cyc !== 8) begin errors++; $display("FAIL random_%0d %h-%h-%b got %h/%b/%b lat %0d exp %h/%b/%b lat 8", n, x, y, b, D, B8, V, cyc, ed, eb, ev); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
